// File: rtl/pulse_length_capture_if.sv
// Record stream from pulse_length_capture: one {channel, level, length} per transfer.
// Show-ahead valid/ready; the payload is meaningful only while out_valid is high.
`default_nettype none

interface pulse_length_capture_if #(
    parameter int CH_W  = 1,
    parameter int CNT_W = 24
);
    logic             out_valid;
    logic             out_ready;
    logic [CH_W-1:0]  out_channel;
    logic             out_level;
    logic [CNT_W-1:0] out_length;

    modport master (
        output out_valid,
        output out_channel,
        output out_level,
        output out_length,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_channel,
        input  out_level,
        input  out_length,
        output out_ready
    );
endinterface

`default_nettype wire

// File: rtl/pulse_length_capture.sv
// pulse_length_capture: multi-channel run-length meter; every synchronised level change
// emits {channel, level held, saturated length} into a shared show-ahead record FIFO.
`default_nettype none

module pulse_length_capture #(
    parameter int CHANNELS    = 2,
    parameter int CNT_W       = 24,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2,
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int AW    = $clog2(DEPTH),
    localparam int REC_W = CH_W + 1 + CNT_W
) (
    input  wire logic                clk50,
    input  wire logic                rst_n,
    input  wire logic [CHANNELS-1:0] sig_in,
    pulse_length_capture_if.master   rec,
    output logic      [AW:0]         fifo_count,
    output logic                     overflow,
    input  wire logic                clr_overflow
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [AW:0]      c_depth   = (AW+1)'(DEPTH);

    logic [CHANNELS-1:0][SYNC_STAGES-1:0] r_sync;
    logic [CHANNELS-1:0]                  r_last;
    logic [CNT_W-1:0]                     r_cnt      [CHANNELS];
    logic [CHANNELS-1:0]                  r_pend;
    logic [CHANNELS-1:0]                  r_pend_level;
    logic [CNT_W-1:0]                     r_pend_len [CHANNELS];

    logic [CHANNELS-1:0] w_s;
    logic [CHANNELS-1:0] w_cap;
    logic [CHANNELS-1:0] w_drain;
    logic [CHANNELS-1:0] w_drop;
    logic                w_gnt_any;
    logic [CH_W-1:0]     w_gnt_idx;

    logic [REC_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [REC_W-1:0] w_push_rec;
    logic [REC_W-1:0] w_head;

    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            w_s[ch] = r_sync[ch][SYNC_STAGES-1];
        end
    end

    assign w_cap = w_s ^ r_last;

    // Fixed priority: scanning downwards lets the lowest pending index win.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int ch = CHANNELS-1; ch >= 0; ch--) begin
            if (r_pend[ch]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = CH_W'(ch);
            end
        end
    end

    assign w_full     = (r_count == c_depth);
    assign w_push     = w_gnt_any && !w_full;
    assign w_pop      = (r_count != '0) && rec.out_ready;
    assign w_push_rec = {w_gnt_idx, r_pend_level[w_gnt_idx], r_pend_len[w_gnt_idx]};

    always_comb begin
        w_drain = '0;
        if (w_push) begin
            w_drain[w_gnt_idx] = 1'b1;
        end
    end

    // A slot that drains this cycle can take the new capture in the same cycle.
    assign w_drop = w_cap & r_pend & ~w_drain;

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            r_sync       <= '0;
            r_last       <= '0;
            r_pend       <= '0;
            r_pend_level <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_cnt[ch]      <= '0;
                r_pend_len[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_sync[ch] <= {r_sync[ch][SYNC_STAGES-2:0], sig_in[ch]};
                if (w_cap[ch]) begin
                    r_last[ch] <= w_s[ch];
                    r_cnt[ch]  <= CNT_W'(1);
                end else if (r_cnt[ch] != c_cnt_max) begin
                    r_cnt[ch] <= r_cnt[ch] + CNT_W'(1);
                end
                if (w_cap[ch] && !w_drop[ch]) begin
                    r_pend[ch]       <= 1'b1;
                    r_pend_level[ch] <= r_last[ch];
                    r_pend_len[ch]   <= r_cnt[ch];
                end else if (w_drain[ch]) begin
                    r_pend[ch] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk50) begin
        if (w_push) begin
            r_mem[r_wr] <= w_push_rec;
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            // Set wins over a simultaneous clear.
            if (|w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign w_head          = (r_count != '0) ? r_mem[r_rd] : '0;
    assign rec.out_valid   = (r_count != '0);
    assign rec.out_channel = w_head[REC_W-1 -: CH_W];
    assign rec.out_level   = w_head[CNT_W];
    assign rec.out_length  = w_head[CNT_W-1:0];
    assign fifo_count      = r_count;
    assign overflow        = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_pulse_length_capture.sv
// Bench for pulse_length_capture: directed scenarios plus randomized toggling, checked by
// a per-channel scoreboard fed from a run-length model of the sampled inputs.
`default_nettype none

module tb_pulse_length_capture;

    localparam int CHANNELS    = 2;
    localparam int CNT_W       = 6;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int CH_W        = 1;
    localparam int AW          = 2;
    localparam int LEN_MAX     = (1 << CNT_W) - 1;

    typedef struct packed {
        logic        lvl;
        logic [31:0] len;
    } exp_t;

    logic                clk50;
    logic                rst_n;
    logic [CHANNELS-1:0] sig_in;
    logic                clr_overflow;
    logic [AW:0]         fifo_count;
    logic                overflow;

    pulse_length_capture_if #(.CH_W(CH_W), .CNT_W(CNT_W)) rec_if ();

    pulse_length_capture #(
        .CHANNELS   (CHANNELS),
        .CNT_W      (CNT_W),
        .DEPTH      (DEPTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk50       (clk50),
        .rst_n       (rst_n),
        .sig_in      (sig_in),
        .rec         (rec_if.master),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .clr_overflow(clr_overflow)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q0[$];
    exp_t q1[$];

    int   m_edge;
    logic [CHANNELS-1:0] m_lvl;
    int   m_last [CHANNELS];
    int   ovf_cnt = -1;

    initial clk50 = 1'b0;
    always #5 clk50 = ~clk50;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Reference: a level change sampled at edge k reaches the synchronised domain at
    // edge k+SYNC_STAGES-1; a record's length is the edge distance between such changes,
    // measured from reset release and capped at the counter maximum.
    always @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            m_edge = 0;
            m_lvl  = '0;
            for (int ch = 0; ch < CHANNELS; ch++) m_last[ch] = 0;
        end else begin
            m_edge++;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (sig_in[ch] !== m_lvl[ch]) begin
                    int   e;
                    int   l;
                    exp_t r;
                    bit   keep;
                    e = m_edge + SYNC_STAGES - 1;
                    l = e - m_last[ch];
                    if (l > LEN_MAX) l = LEN_MAX;
                    r.lvl = m_lvl[ch];
                    r.len = l;
                    keep = 1'b1;
                    // FIFO (DEPTH) plus one pending slot absorb DEPTH+1 records with no consumer.
                    if (ch == 0 && ovf_cnt >= 0) begin
                        ovf_cnt++;
                        if (ovf_cnt == DEPTH + 2) keep = 1'b0;
                    end
                    if (keep) begin
                        if (ch == 0) q0.push_back(r);
                        else         q1.push_back(r);
                    end
                    m_lvl[ch]  = sig_in[ch];
                    m_last[ch] = e;
                end
            end
        end
    end

    always @(negedge clk50) begin
        if (rst_n) begin
            chk("valid_vs_count", {31'd0, rec_if.out_valid}, {31'd0, (fifo_count != 0)});
            if (rec_if.out_valid && rec_if.out_ready) begin
                exp_t e;
                bit   have;
                have = 1'b0;
                if (rec_if.out_channel == 0 && q0.size() > 0) begin
                    e = q0.pop_front(); have = 1'b1;
                end else if (rec_if.out_channel == 1 && q1.size() > 0) begin
                    e = q1.pop_front(); have = 1'b1;
                end
                if (!have) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_record: got ch=%0d lvl=%0d len=%0d expected none",
                             rec_if.out_channel, rec_if.out_level, rec_if.out_length);
                end else begin
                    chk("rec_level", {31'd0, rec_if.out_level}, {31'd0, e.lvl});
                    chk("rec_length", {26'd0, rec_if.out_length}, e.len);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk50);
        #1;
    endtask

    initial begin
        int hold [CHANNELS];
        int zrun;

        rst_n            = 1'b0;
        sig_in           = '0;
        clr_overflow     = 1'b0;
        rec_if.out_ready = 1'b0;
        tick(3);
        chk("rst_valid",    {31'd0, rec_if.out_valid},   0);
        chk("rst_count",    {29'd0, fifo_count},         0);
        chk("rst_overflow", {31'd0, overflow},           0);
        chk("rst_channel",  {31'd0, rec_if.out_channel}, 0);
        chk("rst_level",    {31'd0, rec_if.out_level},   0);
        chk("rst_length",   {26'd0, rec_if.out_length},  0);
        rst_n = 1'b1;

        // First record and edge-to-valid latency
        tick(8);
        sig_in[0] = 1'b1;
        tick(3);
        chk("latency_not_yet", {31'd0, rec_if.out_valid}, 0);
        tick(1);
        chk("latency_valid",   {31'd0, rec_if.out_valid}, 1);
        chk("first_count",     {29'd0, fifo_count},       1);
        chk("first_level",     {31'd0, rec_if.out_level}, 0);
        chk("first_length",    {26'd0, rec_if.out_length}, 10);
        tick(1);
        sig_in[0] = 1'b0;
        rec_if.out_ready = 1'b1;
        tick(10);

        // Both channels change together: ch0 first, ch1 one cycle later
        rec_if.out_ready = 1'b0;
        sig_in = ~sig_in;
        tick(3);
        chk("simul_count0", {29'd0, fifo_count}, 0);
        tick(1);
        chk("simul_count1", {29'd0, fifo_count}, 1);
        chk("simul_head1",  {31'd0, rec_if.out_channel}, 0);
        tick(1);
        chk("simul_count2", {29'd0, fifo_count}, 2);
        chk("simul_head2",  {31'd0, rec_if.out_channel}, 0);
        rec_if.out_ready = 1'b1;
        tick(6);

        // Saturation
        rec_if.out_ready = 1'b0;
        tick(100);
        sig_in[0] = ~sig_in[0];
        tick(4);
        chk("sat_valid",  {31'd0, rec_if.out_valid},   1);
        chk("sat_length", {26'd0, rec_if.out_length},  LEN_MAX);
        rec_if.out_ready = 1'b1;
        tick(6);

        // Push and pop in the same cycle
        rec_if.out_ready = 1'b0;
        sig_in[0] = ~sig_in[0];
        tick(3);
        sig_in[0] = ~sig_in[0];
        tick(1);
        chk("pp_count_a", {29'd0, fifo_count}, 1);
        tick(2);
        chk("pp_count_b", {29'd0, fifo_count}, 1);
        rec_if.out_ready = 1'b1;
        tick(1);
        chk("pp_same_cycle", {29'd0, fifo_count}, 1);
        tick(1);
        chk("pp_drained", {29'd0, fifo_count}, 0);
        tick(10);

        // Overflow: FIFO full, pending slot full, next capture dropped
        rec_if.out_ready = 1'b0;
        ovf_cnt = 0;
        repeat (DEPTH + 2) begin
            sig_in[0] = ~sig_in[0];
            tick(3);
        end
        tick(4);
        chk("ovf_set",   {31'd0, overflow},   1);
        chk("ovf_full",  {29'd0, fifo_count}, DEPTH);
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        chk("ovf_clear", {31'd0, overflow},   0);
        rec_if.out_ready = 1'b1;
        tick(12);
        ovf_cnt = -1;

        // Randomized toggling with a consumer that never stalls long enough to drop
        for (int ch = 0; ch < CHANNELS; ch++) hold[ch] = $urandom_range(8, 20);
        zrun = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (hold[ch] == 0) begin
                    sig_in[ch] = ~sig_in[ch];
                    hold[ch] = ($urandom_range(0, 9) == 0) ? $urandom_range(64, 90)
                                                           : $urandom_range(8, 20);
                end else begin
                    hold[ch]--;
                end
            end
            if (zrun >= 3) rec_if.out_ready = 1'b1;
            else           rec_if.out_ready = ($urandom_range(0, 3) != 0);
            zrun = rec_if.out_ready ? 0 : zrun + 1;
            tick(1);
        end
        rec_if.out_ready = 1'b1;
        tick(30);
        chk("rand_no_overflow", {31'd0, overflow},   0);
        chk("rand_drained",     {29'd0, fifo_count}, 0);

        // Asynchronous reset with records queued
        rec_if.out_ready = 1'b0;
        repeat (3) begin
            sig_in[0] = ~sig_in[0];
            tick(4);
        end
        chk("pre_reset_count", {29'd0, fifo_count}, 3);
        sig_in[0] = ~sig_in[0];
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, rec_if.out_valid}, 0);
        chk("async_rst_count", {29'd0, fifo_count},       0);
        tick(2);
        rst_n = 1'b1;
        rec_if.out_ready = 1'b1;
        tick(40);

        chk("final_q0_empty", q0.size(), 0);
        chk("final_q1_empty", q1.size(), 0);
        chk("final_count",    {29'd0, fifo_count}, 0);
        chk("final_overflow", {31'd0, overflow},   0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pulse_length_capture.md
Name: pulse_length_capture

Overview:
- Multi-channel run-length meter for Morse key inputs: measures how many clk50 cycles each input holds a level.
- On every level change it emits a record {channel, level held, length} into a shared FIFO with a valid/ready output.
- Sits between the board key inputs and the Morse decoder in MAIN.
- Replaces the single-channel, display-only duration counter used during bring-up.

Parameters:
- CHANNELS, 2, number of independent input signals (1..16).
- CNT_W, 24, run-length counter width; lengths saturate at 2^CNT_W-1.
- DEPTH, 8, record FIFO depth (power of 2, >=2).
- SYNC_STAGES, 2, synchroniser flops per input (>=2).
- Derived: CH_W = max(1, clog2(CHANNELS)); AW = clog2(DEPTH).

Ports:
- clk50  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sig_in  in  CHANNELS  raw asynchronous inputs.
- out_valid  out  1  FIFO head record available.
- out_ready  in  1  consumer accepts head record.
- out_channel  out  CH_W  channel of head record.
- out_level  out  1  level that was held.
- out_length  out  CNT_W  cycles the level was held (saturated).
- fifo_count  out  AW+1  records currently stored.
- overflow  out  1  sticky flag: a record was dropped.
- clr_overflow  in  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, sync release by design): all sync flops 0, last_level[ch]=0, cnt[ch]=0, pending flags 0, FIFO empty, out_valid=0, out_channel/out_level/out_length=0, fifo_count=0, overflow=0.
- Synchroniser: s[ch] = sig_in[ch] delayed SYNC_STAGES cycles. Only s is used downstream.
- Per-channel counter, each cycle:
  - If s!=last_level: capture {ch, last_level, cnt} into pend[ch]; last_level<=s; cnt<=1.
  - Otherwise cnt<=min(cnt+1, 2^CNT_W-1). Saturation holds; no wrap.
- Pending slot, one per channel:
  - A capture while pend[ch] is still full and not being drained this cycle drops the new record and sets overflow.
  - A capture in the same cycle pend[ch] drains is accepted.
- Arbiter: each cycle, the lowest-index channel with pend set is pushed into the FIFO if fifo_count<DEPTH, and its pend clears. At most one push per cycle. Fixed priority, no fairness guarantee.
- FIFO:
  - Show-ahead: out_* reflect the head whenever out_valid=1; out_* are don't-care when out_valid=0.
  - out_valid = (fifo_count!=0).
  - Pop when out_valid && out_ready.
  - Full blocks push even if a pop occurs that cycle; push and pop in the same non-full, non-empty cycle leave fifo_count unchanged.
  - Pointers wrap modulo DEPTH.
- Latency:
  - Input edge to s change: SYNC_STAGES cycles.
  - s change to pend set: 1 cycle.
  - Push to out_valid: 1 cycle.
  - Uncontended total: SYNC_STAGES+2 cycles.
- overflow: set on any drop; cleared by clr_overflow. A simultaneous set and clear results in set.
- Reset mid-operation: all records, pending slots and counts are lost immediately. No partial record is emitted after release.
- The first record after reset reports level 0 with length = cycles since reset release, counted as in the per-channel rule.

Test Plan:
- CHANNELS=1, SYNC_STAGES=2: release reset, hold sig_in=0, raise at cycle 10, drop after 5 cycles high -> records {0,0,10} then {0,1,5}. First out_valid appears 4 cycles after the rising input edge.
- CNT_W=4: hold high for 40 cycles, then drop -> record length=15 and the counter does not wrap.
- CHANNELS=2: toggle both inputs in the same cycle -> ch0 record pushed first and ch1 record one cycle later; fifo_count steps 1, 2.
- DEPTH=2, out_ready=0, toggle ch0 every 3 cycles -> FIFO fills (fifo_count=2), pend fills, next capture drops and overflow=1. Then assert clr_overflow with no drop -> overflow=0. Then drain with out_ready=1 -> records are in order and the oldest is preserved.
- out_ready=1 continuously, single toggles -> each record is popped the cycle after out_valid rises; push and pop in the same cycle keep fifo_count constant.
- Assert rst_n low mid-pulse with 3 records queued -> out_valid=0 and fifo_count=0 immediately (asynchronously). After release, no stale record appears.
